// File: rtl/capi_dma_ltag_alloc.sv
// Local-tag allocator: hands free ltags to the read-command issue stage and takes them back from read-data.
// Latency: allocation is 0-cycle from the FIFO head; a returned ltag can be re-offered 1 cycle after its free.
// Backpressure: o_alloc_v holds its offer until i_alloc_r accepts it; frees are always taken (illegal ones are flagged).
module capi_dma_ltag_alloc #(
    parameter int ltag_width = 6,
    parameter int ntags      = 64,
    parameter int cnt_width  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  o_alloc_v,
    input  logic                  i_alloc_r,
    output logic [ltag_width-1:0] o_alloc_ltag,
    input  logic                  i_free_v,
    input  logic [ltag_width-1:0] i_free_ltag,
    output logic [cnt_width-1:0]  o_free_cnt,
    output logic                  o_init_done,
    output logic                  o_idle,
    output logic                  o_err_v,
    output logic [ltag_width-1:0] o_err_ltag
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ltag_width-1:0] r_fifo [ntags];
    logic [ltag_width:0]   r_rd_ptr;
    logic [ltag_width:0]   r_wr_ptr;
    logic [ltag_width-1:0] r_init_cnt;
    logic [ntags-1:0]      r_bitmap;
    logic                  r_err_v;
    logic [ltag_width-1:0] r_err_ltag;

    logic                  w_run;
    logic                  w_init_wr;
    logic [cnt_width-1:0]  w_free_cnt;
    logic [ltag_width-1:0] w_head;
    logic                  w_accept;
    logic                  w_free_ok;
    logic                  w_free_bad;
    logic                  w_fifo_we;
    logic [ltag_width-1:0] w_fifo_wdat;
    logic [ntags-1:0]      w_bitmap_nxt;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    // FSM next state: INIT lasts exactly ntags cycles, RUN is left only by reset
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && r_init_cnt == ltag_width'(ntags - 1))
            w_state_nxt = ST_RUN;
    end

    // FSM outputs: INIT writes the ascending ltag sequence, RUN enables alloc/free
    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_init_wr = (r_state == ST_INIT);
    end

    // Datapath decode; pointer difference is the free count (full when only MSBs differ)
    always_comb begin
        w_free_cnt  = w_run ? cnt_width'(r_wr_ptr - r_rd_ptr) : '0;
        w_head      = r_fifo[r_rd_ptr[ltag_width-1:0]];
        w_accept    = w_run && (w_free_cnt != '0) && i_alloc_r;
        // bitmap is checked before this cycle's accept updates it
        w_free_ok   = w_run && i_free_v && r_bitmap[i_free_ltag];
        w_free_bad  = i_free_v && !w_free_ok;
        w_fifo_we   = w_init_wr || w_free_ok;
        w_fifo_wdat = w_init_wr ? r_init_cnt : i_free_ltag;
    end

    // In-use bitmap next value: set on accept, clear on legal free
    always_comb begin
        w_bitmap_nxt = r_bitmap;
        if (w_accept)  w_bitmap_nxt[w_head]      = 1'b1;
        if (w_free_ok) w_bitmap_nxt[i_free_ltag] = 1'b0;
    end

    // Free-list storage; contents are rebuilt by INIT so no reset is needed
    always_ff @(posedge clk) begin
        if (w_fifo_we) r_fifo[r_wr_ptr[ltag_width-1:0]] <= w_fifo_wdat;
    end

    // Pointers, init counter and bitmap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_init_cnt <= '0;
            r_bitmap   <= '0;
        end else begin
            if (w_fifo_we) r_wr_ptr   <= r_wr_ptr + 1'b1;
            if (w_accept)  r_rd_ptr   <= r_rd_ptr + 1'b1;
            if (w_init_wr) r_init_cnt <= r_init_cnt + 1'b1;
            r_bitmap <= w_bitmap_nxt;
        end
    end

    // Sticky error; only the first offending ltag is kept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_v    <= 1'b0;
            r_err_ltag <= '0;
        end else if (w_free_bad) begin
            r_err_v <= 1'b1;
            if (!r_err_v) r_err_ltag <= i_free_ltag;
        end
    end

    // Output drive; the offered ltag is forced to 0 outside RUN
    always_comb begin
        o_alloc_v    = w_run && (w_free_cnt != '0);
        o_alloc_ltag = w_run ? w_head : '0;
        o_free_cnt   = w_free_cnt;
        o_init_done  = w_run;
        o_idle       = w_run && (w_free_cnt == cnt_width'(ntags));
        o_err_v      = r_err_v;
        o_err_ltag   = r_err_ltag;
    end

endmodule

// File: tb/tb_capi_dma_ltag_alloc.sv
module tb_capi_dma_ltag_alloc;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_alloc_r = 1'b0;
    logic       i_free_v = 1'b0;
    logic [5:0] i_free_ltag = '0;
    logic       o_alloc_v;
    logic [5:0] o_alloc_ltag;
    logic [6:0] o_free_cnt;
    logic       o_init_done;
    logic       o_idle;
    logic       o_err_v;
    logic [5:0] o_err_ltag;

    int checks = 0;
    int errors = 0;

    capi_dma_ltag_alloc dut (
        .clk          (clk),
        .reset        (reset),
        .o_alloc_v    (o_alloc_v),
        .i_alloc_r    (i_alloc_r),
        .o_alloc_ltag (o_alloc_ltag),
        .i_free_v     (i_free_v),
        .i_free_ltag  (i_free_ltag),
        .o_free_cnt   (o_free_cnt),
        .o_init_done  (o_init_done),
        .o_idle       (o_idle),
        .o_err_v      (o_err_v),
        .o_err_ltag   (o_err_ltag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the free list is an ordered queue of ltags, in-use is a flag per ltag.
    int unsigned q[$];
    bit          inuse[64];
    int          init_left;
    bit          m_run;
    bit          m_err;
    int          m_err_ltag;
    bit          mon_en = 1'b0;
    int unsigned got[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            foreach (inuse[k]) inuse[k] = 1'b0;
            init_left  = 64;
            m_run      = 1'b0;
            m_err      = 1'b0;
            m_err_ltag = 0;
        end else if (!m_run) begin
            if (i_free_v) begin
                if (!m_err) m_err_ltag = int'(i_free_ltag);
                m_err = 1'b1;
            end
            init_left--;
            if (init_left == 0) begin
                m_run = 1'b1;
                for (int k = 0; k < 64; k++) q.push_back(k);
            end
        end else begin
            bit legal;
            legal = i_free_v && inuse[i_free_ltag];
            if (i_free_v && !legal) begin
                if (!m_err) m_err_ltag = int'(i_free_ltag);
                m_err = 1'b1;
            end
            if (i_alloc_r && q.size() != 0) inuse[q.pop_front()] = 1'b1;
            if (legal) begin
                q.push_back(int'(i_free_ltag));
                inuse[i_free_ltag] = 1'b0;
            end
        end
    end

    // Monitor: compares every DUT output against the model away from the clock edge
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_v;
            exp_v = m_run && q.size() != 0;
            chk("alloc_v", int'(o_alloc_v), int'(exp_v));
            if (exp_v && o_alloc_v) chk("alloc_ltag", int'(o_alloc_ltag), int'(q[0]));
            if (!m_run) chk("alloc_ltag_init", int'(o_alloc_ltag), 0);
            chk("free_cnt", int'(o_free_cnt), q.size());
            chk("init_done", int'(o_init_done), int'(m_run));
            chk("idle", int'(o_idle), int'(m_run && q.size() == 64));
            chk("err_v", int'(o_err_v), int'(m_err));
            chk("err_ltag", int'(o_err_ltag), m_err_ltag);
            if (o_alloc_v && i_alloc_r) got.push_back(int'(o_alloc_ltag));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic free1(input int t);
        i_free_v    = 1'b1;
        i_free_ltag = 6'(t);
        step();
        i_free_v    = 1'b0;
    endtask

    task automatic wait_offer(input string nm, input int exp_cycles);
        int n = 0;
        while (!o_alloc_v && n < 200) begin
            step();
            n++;
        end
        chk(nm, n, exp_cycles);
    endtask

    initial begin
        int inuse_list[$];

        // 1: reset, then INIT lasts 64 cycles and ltag 0 is offered
        #1 reset = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        wait_offer("init_latency", 64);
        chk("first_ltag", int'(o_alloc_ltag), 0);
        chk("first_cnt", int'(o_free_cnt), 64);
        chk("first_idle", int'(o_idle), 1);

        // 2: drain all 64 in order
        got.delete();
        i_alloc_r = 1'b1;
        repeat (64) step();
        i_alloc_r = 1'b0;
        chk("drain_count", got.size(), 64);
        for (int k = 0; k < 64 && k < got.size(); k++) chk("drain_order", int'(got[k]), k);
        chk("drain_v", int'(o_alloc_v), 0);
        chk("drain_idle", int'(o_idle), 0);

        // 3: free into empty list shows up next cycle
        free1(8'h2A);
        chk("reoffer_v", int'(o_alloc_v), 1);
        chk("reoffer_ltag", int'(o_alloc_ltag), 8'h2A);
        chk("reoffer_cnt", int'(o_free_cnt), 1);

        // 4: double free of 5 latches error; later double free of 9 keeps 5
        free1(5);
        free1(5);
        chk("dbl_err_v", int'(o_err_v), 1);
        chk("dbl_err_ltag", int'(o_err_ltag), 5);
        chk("dbl_cnt", int'(o_free_cnt), 2);
        free1(9);
        free1(9);
        chk("dbl2_err_ltag", int'(o_err_ltag), 5);
        chk("dbl2_cnt", int'(o_free_cnt), 3);

        // 5: with 10 free, accept and legal free together keep the count
        for (int t = 10; t < 17; t++) free1(t);
        chk("ten_cnt", int'(o_free_cnt), 10);
        i_alloc_r = 1'b1;
        free1(20);
        i_alloc_r = 1'b0;
        chk("same_cyc_cnt", int'(o_free_cnt), 10);
        // freeing the ltag that is accepted in the same cycle is a double free
        i_alloc_r = 1'b1;
        free1(int'(o_alloc_ltag));
        i_alloc_r = 1'b0;
        chk("same_ltag_cnt", int'(o_free_cnt), 9);
        chk("same_ltag_err", int'(o_err_ltag), 5);

        // random traffic, mostly legal frees of ltags the model says are in use
        repeat (600) begin
            i_alloc_r = ($urandom_range(0, 99) < 55);
            inuse_list.delete();
            foreach (inuse[k]) if (inuse[k]) inuse_list.push_back(k);
            i_free_v = ($urandom_range(0, 99) < 50);
            if (inuse_list.size() != 0 && $urandom_range(0, 99) < 90)
                i_free_ltag = 6'(inuse_list[$urandom_range(0, inuse_list.size() - 1)]);
            else
                i_free_ltag = 6'($urandom_range(0, 63));
            step();
        end
        i_alloc_r = 1'b0;
        i_free_v  = 1'b0;
        step();

        // 6: fresh start, allocate 20, then reset mid-stream
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_offer("reinit_latency", 64);
        i_alloc_r = 1'b1;
        repeat (20) step();
        chk("mid_cnt", int'(o_free_cnt), 44);
        reset = 1'b1;
        #1;
        chk("rst_alloc_v", int'(o_alloc_v), 0);
        chk("rst_ltag", int'(o_alloc_ltag), 0);
        chk("rst_cnt", int'(o_free_cnt), 0);
        chk("rst_init_done", int'(o_init_done), 0);
        chk("rst_idle", int'(o_idle), 0);
        chk("rst_err", int'(o_err_v), 0);
        i_alloc_r = 1'b0;
        step();
        reset = 1'b0;
        wait_offer("post_rst_latency", 64);
        chk("post_rst_cnt", int'(o_free_cnt), 64);
        chk("post_rst_ltag", int'(o_alloc_ltag), 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
